// File: rtl/revaluate_reader.sv
// Streams the ROWSxCOLS result matrix out of a sync-read memory, row-major, over valid/ready.
// Optional out_last port enabled by defining REVALUATE_READER_LAST_EN.
module revaluate_reader #(
  parameter int DATA_W = 64,
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef REVALUATE_READER_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic               w_last;
  logic               w_col_last;

  assign w_col_last = (r_col == COL_W'(COLS - 1));
  assign w_last     = (r_row == ROW_W'(ROWS - 1)) && w_col_last;

  // r_addr tracks row*COLS+col incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_state <= S_LOAD;
        S_LOAD: r_state <= S_CAPT;
        S_CAPT: begin
          r_data  <= rd_data;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            if (w_last) begin
              r_row   <= '0;
              r_col   <= '0;
              r_addr  <= '0;
              r_state <= S_DONE;
            end else begin
              if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
              end else begin
                r_col <= r_col + COL_W'(1);
              end
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en     = (r_state == S_LOAD);
  assign rd_addr   = r_addr;
  assign out_data  = r_data;
  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

`ifdef REVALUATE_READER_LAST_EN
  assign out_last  = (r_state == S_HOLD) && w_last;
`endif

endmodule

// File: tb/tb_revaluate_reader.sv
// Scoreboard bench for revaluate_reader: stimulus queues expected words, a negedge monitor pops and compares.
module tb_revaluate_reader;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef REVALUATE_READER_LAST_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  revaluate_reader #(.DATA_W(DW), .ROWS(5), .COLS(5), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef REVALUATE_READER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  logic [DW-1:0] mem [0:31];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'h100 + 64'(i);
    rd_data = '0;
  end
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            n_acc = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] prev_data = '0;
  logic          prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      if (out_valid && prev_stall) check("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("word", out_data, e);
`ifdef REVALUATE_READER_LAST_EN
          check("out_last", 64'(out_last), 64'(e == 64'h118));
`endif
          n_acc++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"},     64'(rd_en),     64'd0);
    check({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
    check({tag, "_out_data"},  out_data,       64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
`ifdef REVALUATE_READER_LAST_EN
    check({tag, "_out_last"},  64'(out_last),  64'd0);
`endif
  endtask

  // Called at posedge+1 in an IDLE cycle; start is sampled at the next edge.
  // mode 0: ready high; mode 1: random ready; mode 2: ready high plus stray starts.
  task automatic readout(input int mode);
    int c0;
    int n;
    int budget;
    start    = 1'b1;
    n_acc    = 0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) exp_q.push_back(64'h100 + 64'(i));
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    check("c1_rd_en",   64'(rd_en),   64'd1);
    check("c1_rd_addr", 64'(rd_addr), 64'd0);
    check("c1_busy",    64'(busy),    64'd1);
    budget = 0;
    while (done_cnt == 0 && budget < 2000) begin
      n = cyc - c0 + 1;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2) start = (n == 5 || n == 40);
      @(posedge clk); #1;
      budget++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done_pulse");
    end
    check("done_count",  64'(done_cnt),     64'd1);
    check("words_acc",   64'(n_acc),        64'd25);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (mode != 1) check("done_cycle", 64'(done_cyc - c0 + 1), 64'd76);
    check("post_busy",   64'(busy),         64'd0);
    check("post_done",   64'(done),         64'd0);
    exp_q.delete();
  endtask

  initial begin
    int budget;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    readout(0);
    repeat (3) @(posedge clk);
    #1;
    readout(1);
    repeat (2) @(posedge clk);
    #1;
    readout(2);
    // back-to-back: start in the cycle right after done
    readout(0);

    // mid-stream reset while word 12 is stalled in HOLD
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b1;
    n_acc    = 0;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) exp_q.push_back(64'h100 + 64'(i));
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 0;
    while (!(out_valid && n_acc == 12) && budget < 500) begin
      out_ready = (n_acc < 12);
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    check("pre_reset_word",  out_data,       64'h10C);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check_idle_outputs("abort");
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(done), 64'd0);
    end
    check("abort_done_cnt", 64'(done_cnt), 64'd0);
    readout(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/revaluate_reader.md
# revaluate_reader

Reads the 5x5 result matrix out of the revaluate-stage result memory after the encoder reports completion and streams it word by word over a valid/ready output. It is the read-side counterpart of the revaluate controller, which writes the matrix. It sits between the result memory's synchronous read port and the downstream consumer. Sequencing is a small FSM with row/column counters and one outstanding memory read.

## Interface
Parameters:
- DATA_W, 64, width of one matrix word
- ROWS, 5, matrix rows
- COLS, 5, matrix columns
- ADDR_W, 5, memory address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin readout; sampled only in IDLE
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory word address, row*COLS+col
- rd_data  in  DATA_W  memory read data, valid exactly one cycle after rd_en
- out_data  out  DATA_W  streamed word (registered)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, LOAD, CAPT, HOLD, DONE.
- IDLE: outputs inactive; row=col=0. start=1 -> LOAD, else stay.
- LOAD: rd_en=1, rd_addr=row*COLS+col -> CAPT unconditionally.
- CAPT: out_data <= rd_data at end of cycle -> HOLD.
- HOLD: out_valid=1, out_data stable. On out_ready=1: if row==ROWS-1 && col==COLS-1 -> DONE, else advance counters -> LOAD. out_ready=0: stay, hold data.
- Counter advance: col==COLS-1 -> col=0, row=row+1; else col=col+1. Counters never exceed ROWS-1/COLS-1; reset to 0 on entering DONE.
- DONE: done=1 for one cycle -> IDLE.
- Word order: row-major, addresses 0..ROWS*COLS-1 exactly once each.
- start outside IDLE ignored (no restart, no queuing); start in DONE ignored.
- rst=1 at any clock edge (including mid-readout): state IDLE, row=col=0, out_data=0; stream aborted, no done pulse.
- out_valid, rd_en, busy, done are decoded from state (Moore); out_data is a register.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0.
- start sampled at edge E0 -> LOAD in cycle 1 (rd_en=1, addr 0) -> CAPT cycle 2 -> out_valid=1 from cycle 3.
- Per word with out_ready held high: 3 cycles (LOAD, CAPT, HOLD). Full 5x5 matrix: 75 cycles, done in cycle 76, busy high cycles 1..76.
- out_ready low stalls only in HOLD; no data loss or duplication.
- rd_addr outside LOAD: held at current row*COLS+col; consumers must qualify with rd_en.

## Configuration
- REVALUATE_READER_LAST_EN defined: adds output port out_last (1 bit), high in HOLD when row==ROWS-1 && col==COLS-1, else 0; reset 0.
- Not defined: no out_last port; all other behaviour identical.

## Test plan
- Memory preloaded with word[i]=i+0x100, out_ready=1, pulse start -> 25 words 0x100..0x118 in order, 75 cycles, done pulses once in cycle 76, busy falls after it.
- out_ready toggled randomly (~50%) -> same 25-word sequence, no repeats or drops; out_data stable while out_valid && !out_ready.
- start pulsed again in cycles 5 and 40 of a readout -> ignored; exactly 25 words and one done.
- rst asserted while in HOLD of word 12 -> next cycle all outputs 0, state IDLE; new start restarts from address 0.
- Back-to-back: start in the cycle after done -> second full readout starts at address 0, rd_en in the following cycle.
- With REVALUATE_READER_LAST_EN: out_last high only with word 24 (0x118); without it, port absent and the first test still passes.
